// File: rtl/vga_bar_decoder.sv
// Purpose : measures VGA line/frame timing from pixel-strobed sync inputs and counts
//           WHITE pixels on one chosen line per frame.
// Latency : outputs and frame_done update 1 clk after the vsync-fall pixel strobe.
// Backpr. : none; the block samples only on pix_en strobes and can never stall its source.
//
// Ports
//   clk, rst_n            : system clock, async active-low reset
//   pix_en                : one-clk pixel strobe; all other inputs are ignored while low
//   hsync_in, vsync_in    : active-low syncs, synchronous to clk
//   r_in, g_in, b_in      : 4-bit pixel colour
//   h_total, hs_width     : pixels per line / pixels per line with hsync low
//   v_total               : lines per frame
//   white_cnt             : WHITE pixels seen on MEAS_LINE in the last complete frame
//   lock                  : timing stable for two consecutive frames
//   frame_done            : one-clk pulse when the outputs above update
module vga_bar_decoder #(
    parameter logic [9:0]  MEAS_LINE = 10'd235,
    parameter logic [11:0] WHITE     = 12'hFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [3:0] r_in,
    input  logic [3:0] g_in,
    input  logic [3:0] b_in,
    output logic [9:0] h_total,
    output logic [9:0] hs_width,
    output logic [9:0] v_total,
    output logic [9:0] white_cnt,
    output logic       lock,
    output logic       frame_done
);

    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {IDLE, ALIGN, LOCKED} state_t;

    state_t     state, state_nxt;

    logic       prev_hs, prev_vs;
    logic [9:0] pix_cnt, hs_cnt, line_cnt, wcnt;
    logic [9:0] h_line_len, hs_len, v_len;
    logic [9:0] ref_h, ref_v;
    logic       ref_vld;
    logic       sat_seen;

    logic       hs_fall, hs_rise, vs_fall;
    logic       pix_white;
    logic       frame_sat;
    logic [9:0] h_meas, v_meas;
    logic       meas_match;
    logic       upd, store;

    // Length latches saturate too, so a saturated counter reports 1023 rather than wrapping to 0.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    assign hs_fall   = pix_en &  prev_hs & ~hsync_in;
    assign hs_rise   = pix_en & ~prev_hs &  hsync_in;
    assign vs_fall   = pix_en &  prev_vs & ~vsync_in;
    assign pix_white = ({r_in, g_in, b_in} == WHITE);

    // The vsync fall usually coincides with an hsync fall; use the line length being
    // latched on this same strobe rather than the stale h_line_len register.
    assign h_meas     = hs_fall ? sat_inc(pix_cnt) : h_line_len;
    assign v_meas     = sat_inc(line_cnt);
    assign meas_match = (h_meas == ref_h) && (v_meas == ref_v);

    // Counters sitting at 1023 on the closing strobe count as saturated in this frame.
    assign frame_sat  = sat_seen || (pix_cnt == CNT_MAX) || (hs_cnt == CNT_MAX) ||
                        (line_cnt == CNT_MAX);

    // Sync history, advanced only on pixel strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_hs <= 1'b1;
            prev_vs <= 1'b1;
        end else if (pix_en) begin
            prev_hs <= hsync_in;
            prev_vs <= vsync_in;
        end
    end

    // Pixels per line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt    <= 10'd0;
            h_line_len <= 10'd0;
        end else if (hs_fall) begin
            h_line_len <= sat_inc(pix_cnt);
            pix_cnt    <= 10'd0;
        end else if (pix_en) begin
            pix_cnt    <= sat_inc(pix_cnt);
        end
    end

    // Hsync pulse width: the fall sample itself counts as the first low pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_cnt <= 10'd0;
            hs_len <= 10'd0;
        end else begin
            if (hs_fall) begin
                hs_cnt <= 10'd1;
            end else if (pix_en && !hsync_in) begin
                hs_cnt <= sat_inc(hs_cnt);
            end
            if (hs_rise) begin
                hs_len <= hs_cnt;
            end
        end
    end

    // Lines per frame; a vsync fall takes priority over a coincident hsync fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt <= 10'd0;
            v_len    <= 10'd0;
        end else if (vs_fall) begin
            v_len    <= v_meas;
            line_cnt <= 10'd0;
        end else if (hs_fall) begin
            line_cnt <= sat_inc(line_cnt);
        end
    end

    // White pixel count on the measurement line, and the per-frame saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt     <= 10'd0;
            sat_seen <= 1'b0;
        end else if (vs_fall) begin
            wcnt     <= 10'd0;
            sat_seen <= 1'b0;
        end else begin
            if (pix_en && (line_cnt == MEAS_LINE) && pix_white) begin
                wcnt <= sat_inc(wcnt);
            end
            if ((pix_cnt == CNT_MAX) || (hs_cnt == CNT_MAX) || (line_cnt == CNT_MAX)) begin
                sat_seen <= 1'b1;
            end
        end
    end

    // Lock FSM: all decisions are taken on vsync-fall strobes only.
    always_comb begin
        state_nxt = state;
        upd       = 1'b0;
        store     = 1'b0;
        if (vs_fall) begin
            case (state)
                IDLE: begin
                    // First fall only marks frame start; the frame before it was partial.
                    state_nxt = ALIGN;
                end
                ALIGN: begin
                    upd   = 1'b1;
                    store = 1'b1;
                    if (ref_vld && meas_match && !frame_sat) begin
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    upd   = 1'b1;
                    store = 1'b1;
                    if (!meas_match || frame_sat) begin
                        state_nxt = ALIGN;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lock       <= 1'b0;
            frame_done <= 1'b0;
            ref_h      <= 10'd0;
            ref_v      <= 10'd0;
            ref_vld    <= 1'b0;
            h_total    <= 10'd0;
            hs_width   <= 10'd0;
            v_total    <= 10'd0;
            white_cnt  <= 10'd0;
        end else begin
            state      <= state_nxt;
            // Driven from next state so lock always equals (state == LOCKED).
            lock       <= (state_nxt == LOCKED);
            frame_done <= upd;
            if (store) begin
                ref_h   <= h_meas;
                ref_v   <= v_meas;
                ref_vld <= 1'b1;
            end
            if (upd) begin
                h_total   <= h_meas;
                hs_width  <= hs_len;
                v_total   <= v_meas;
                white_cnt <= wcnt;
            end
        end
    end

endmodule

// File: tb/tb_vga_bar_decoder.sv
// Purpose : directed checks of vga_bar_decoder on a reduced raster (20 px x 30 lines).
// Latency : expects frame_done 1 clk after each vsync-fall strobe outside IDLE.
// Backpr. : none; stimulus is driven freely on negedges.
module tb_vga_bar_decoder;

    localparam int HLEN  = 20;
    localparam int HSLOW = 3;
    localparam int VLEN  = 30;
    localparam int VSLOW = 2;
    localparam int WLINE = 12;

    logic       clk;
    logic       rst_n;
    logic       pix_en;
    logic       hsync_in;
    logic       vsync_in;
    logic [3:0] r_in, g_in, b_in;
    logic [9:0] h_total, hs_width, v_total, white_cnt;
    logic       lock, frame_done;

    vga_bar_decoder #(.MEAS_LINE(10'd12), .WHITE(12'hFFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .h_total    (h_total),
        .hs_width   (hs_width),
        .v_total    (v_total),
        .white_cnt  (white_cnt),
        .lock       (lock),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Snapshot of outputs at every frame_done pulse, plus pulse-width tracking.
    int         fd_cnt  = 0;
    int         fd_wide = 0;
    logic       fd_prev = 1'b0;
    logic [9:0] s_h, s_hs, s_v, s_w;
    logic       s_lock;
    logic       last_fd, first_fd;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt++;
            s_h    = h_total;
            s_hs   = hs_width;
            s_v    = v_total;
            s_w    = white_cnt;
            s_lock = lock;
            if (fd_prev) fd_wide++;
        end
        fd_prev = frame_done;
    end

    // One pixel strobe; called on a negedge, returns on a negedge.
    task automatic send_pix(input logic hs, input logic vs, input logic [11:0] rgb, input int gap);
        hsync_in = hs;
        vsync_in = vs;
        {r_in, g_in, b_in} = rgb;
        pix_en = 1'b1;
        @(negedge clk);
        last_fd = frame_done;
        pix_en = 1'b0;
        for (int i = 1; i < gap; i++) @(negedge clk);
    endtask

    // One frame; its first strobe carries the vsync fall (unless vs_hold).
    task automatic run_frame(input int nlines, input int gap, input bit white, input bit vs_hold);
        logic [11:0] px;
        logic        hs, vs;
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < HLEN; p++) begin
                hs = (p < HSLOW) ? 1'b0 : 1'b1;
                vs = (l < VSLOW && !vs_hold) ? 1'b0 : 1'b1;
                px = 12'h000;
                if (white) begin
                    if (l == WLINE && p >= 5 && p <= 12) px = 12'hFFF;
                    if (l == WLINE && p == 14)           px = 12'hFFE;
                    if (l == WLINE - 1 && p == 5)        px = 12'hFFF;
                end
                send_pix(hs, vs, px, gap);
                if (l == 0 && p == 0) first_fd = last_fd;
            end
        end
    endtask

    task automatic check_upd(input string tag, input int h, input int v, input int w, input int lk);
        check_eq({tag, ".h_total"},  32'(s_h),    h);
        check_eq({tag, ".hs_width"}, 32'(s_hs),   HSLOW);
        check_eq({tag, ".v_total"},  32'(s_v),    v);
        check_eq({tag, ".white"},    32'(s_w),    w);
        check_eq({tag, ".lock"},     32'(s_lock), lk);
    endtask

    int fd_before;

    initial begin
        rst_n    = 1'b0;
        pix_en   = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        {r_in, g_in, b_in} = 12'h000;
        first_fd = 1'b0;
        last_fd  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst.h_total",    32'(h_total),    0);
        check_eq("rst.v_total",    32'(v_total),    0);
        check_eq("rst.lock",       32'(lock),       0);
        check_eq("rst.frame_done", 32'(frame_done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Acquisition with pix_en every 4th clk.
        run_frame(VLEN, 4, 1'b0, 1'b0);
        check_eq("idle.no_update", fd_cnt, 0);
        run_frame(VLEN, 4, 1'b0, 1'b0);
        check_eq("f1.count", fd_cnt, 1);
        check_eq("f1.latency", 32'(first_fd), 1);
        check_upd("f1", HLEN, VLEN, 0, 0);
        run_frame(VLEN, 4, 1'b1, 1'b0);
        check_upd("f2", HLEN, VLEN, 0, 1);
        run_frame(VLEN, 2, 1'b0, 1'b0);
        check_upd("white", HLEN, VLEN, 8, 1);
        check_eq("white.latency", 32'(first_fd), 1);

        // Short frame drops lock, two good frames relock.
        run_frame(VLEN - 1, 2, 1'b0, 1'b0);
        check_upd("pre_short", HLEN, VLEN, 0, 1);
        run_frame(VLEN, 2, 1'b0, 1'b0);
        check_upd("short", HLEN, VLEN - 1, 0, 0);
        check_eq("short.lock_live", 32'(lock), 0);
        run_frame(VLEN, 2, 1'b0, 1'b0);
        check_upd("relock1", HLEN, VLEN, 0, 0);
        run_frame(VLEN, 2, 1'b0, 1'b0);
        check_upd("relock2", HLEN, VLEN, 0, 1);

        // Inputs toggled with pix_en low must be invisible.
        fd_before = fd_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            {r_in, g_in, b_in} = 12'($urandom);
        end
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        check_eq("noen.fd_count", fd_cnt, fd_before);
        check_eq("noen.h_total",  32'(h_total), HLEN);
        check_eq("noen.v_total",  32'(v_total), VLEN);
        check_eq("noen.lock",     32'(lock),    1);
        run_frame(VLEN, 1, 1'b0, 1'b0);
        check_eq("noen.fd_next", fd_cnt, fd_before + 1);
        check_upd("noen.next", HLEN, VLEN, 0, 1);

        // Vsync absent for 1100 lines: line counter saturates, lock drops.
        run_frame(1100, 1, 1'b0, 1'b1);
        run_frame(VLEN, 1, 1'b0, 1'b0);
        check_upd("sat", HLEN, 1023, 0, 0);

        // Reset mid-frame.
        run_frame(5, 1, 1'b0, 1'b0);
        check_upd("post_sat", HLEN, VLEN, 0, 0);
        rst_n = 1'b0;
        #1;
        check_eq("mrst.h_total",    32'(h_total),    0);
        check_eq("mrst.hs_width",   32'(hs_width),   0);
        check_eq("mrst.v_total",    32'(v_total),    0);
        check_eq("mrst.white",      32'(white_cnt),  0);
        check_eq("mrst.lock",       32'(lock),       0);
        check_eq("mrst.frame_done", 32'(frame_done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fd_before = fd_cnt;
        run_frame(VLEN, 1, 1'b0, 1'b0);
        check_eq("mrst.idle_no_update", fd_cnt, fd_before);
        run_frame(VLEN, 1, 1'b0, 1'b0);
        check_eq("mrst.first_update", fd_cnt, fd_before + 1);
        check_upd("mrst.frame", HLEN, VLEN, 0, 0);

        check_eq("frame_done.width", fd_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
